paralelo_serial: RTL and testbench
==================================

// Module: paralelo_serial
// PURPOSE
//  Byte-to-serial transmitter for the PCIe-style PHY lane; the other end of serial_paralelo.
//  Runs on a single clk_32f clock, so one serial bit is sent per clock and one symbol every 8 clocks.
//  After reset it sends SYNC_COUNT COM symbols for receiver alignment, then goes active.
//  Once active it sends a user byte when one is offered, otherwise the IDLE symbol. Bits go out MSB first.
// PARAMETERS
//  COM_SYMBOL   8'hBC  alignment symbol sent during SYNC
//  IDLE_SYMBOL  8'h7C  filler symbol sent in ACTIVE when valid_in=0 at a load
//  SYNC_COUNT   4      number of COM symbols sent before ACTIVE (>=1)
//  CNT_WIDTH    16     width of data_byte_cnt
// PORTS
//  clk_32f        in   1          serial bit clock; all logic on posedge
//  reset          in   1          synchronous, active-low reset
//  valid_in       in   1          data_in holds a byte to send
//  data_in        in   8          parallel byte; sampled only on an edge where ready=1
//  ready          out  1          combinational; high in the cycle whose closing edge loads a user/idle symbol
//  data_out       out  1          registered serial bit stream, MSB first
//  active         out  1          registered; high while in the ACTIVE state
//  data_byte_cnt  out  CNT_WIDTH  count of user bytes loaded; wraps to 0
// BEHAVIOUR
//  Reset (edge with reset=0):
//   - Outputs: data_out=0, active=0, data_byte_cnt=0.
//   - Internal: bit_cnt=0, shift_reg=0, sync_cnt=0, state=SYNC.
//   - ready=0 while reset=0.
//  Bit counter: bit_cnt (3b) advances 0..7 and wraps on every edge with reset=1.
//  Load edge: an edge with reset=1 and bit_cnt==0.
//   - shift_reg<=sym and data_out<=sym[7] on that edge.
//   - On the next 7 edges data_out<=sym[6]..sym[0], so latency is load edge -> MSB on data_out.
//  State SYNC:
//   - sym=COM_SYMBOL; valid_in and data_in are ignored; ready=0.
//   - sync_cnt++ on each load. On the load with sync_cnt==SYNC_COUNT-1: state<=ACTIVE and active<=1 on that edge.
//  State ACTIVE:
//   - ready = reset & (bit_cnt==0).
//   - valid_in=1 at a load: sym=data_in and data_byte_cnt++ (wraps all-ones -> 0).
//   - valid_in=0 at a load: sym=IDLE_SYMBOL; count unchanged.
//   - data_in equal to COM/IDLE is sent transparently; no escaping.
//   - valid_in/data_in changes on non-load edges have no effect.
//   - No exit from ACTIVE except reset.
//  Mid-symbol reset:
//   - The current symbol is aborted; the reset values above apply on the next edge.
//   - The SYNC sequence restarts in full after reset is released.
//  Timeline, with edge 1 = first edge with reset=1:
//   - COM loads on edges 1, 9, 17, 25; active rises on edge 25.
//   - ready is high in the cycle after edge 32; the first user/idle load is edge 33.
// TESTING
//  T1 reset=0 for 3 edges, then 1, valid_in=0 -> data_out = 10111100 x4 on edges 1-32; active=1 after edge 25; then 01111100 repeated.
//  T2 after T1, valid_in=1, data_in=8'hA5 while ready -> data_out 1,0,1,0,0,1,0,1 on edges 33-40; data_byte_cnt=1 after edge 33.
//  T3 back-to-back 8'h00, 8'hFF, 8'hBC with valid_in held 1 -> 24 bits exactly those bytes, MSB first; data_byte_cnt=3.
//  T4 valid_in pulsed high only on edges 35-38 (non-load), low at edges 33 and 41 -> 7C sent twice; data_byte_cnt unchanged.
//  T5 reset=0 at bit 4 of a data byte -> next edge data_out=0, active=0, data_byte_cnt=0; after release 4 COMs, active after 25th edge.
//  T6 CNT_WIDTH=4 with 17 consecutive valid loads -> data_byte_cnt reads 15 after the 15th, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/paralelo_serial.sv
// paralelo_serial: byte-to-serial transmitter for one PHY lane.
// One bit leaves per clock and one symbol every 8 clocks, MSB first.
// After reset the lane sends SYNC_COUNT COM symbols for alignment.
// It then stays ACTIVE, sending user bytes when offered and IDLE otherwise.
module paralelo_serial #(
    parameter logic [7:0] COM_SYMBOL  = 8'hBC,
    parameter logic [7:0] IDLE_SYMBOL = 8'h7C,
    parameter int         SYNC_COUNT  = 4,
    parameter int         CNT_WIDTH   = 16
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic [7:0]           data_in,
    output logic                 ready,
    output logic                 data_out,
    output logic                 active,
    output logic [CNT_WIDTH-1:0] data_byte_cnt
);

    // sync_cnt only has to reach SYNC_COUNT-1, so size it for that value.
    localparam int SW = (SYNC_COUNT < 2) ? 1 : $clog2(SYNC_COUNT);
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_COUNT - 1);

    typedef enum logic {S_SYNC, S_ACTIVE} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_shift;
    logic [SW-1:0]        r_sync_cnt;
    logic                 r_data_out;
    logic                 r_active;
    logic [CNT_WIDTH-1:0] r_byte_cnt;

    logic                 w_load;
    logic                 w_ready;
    logic                 w_user_load;
    logic [7:0]           w_sym;

    // A new symbol is loaded whenever the bit counter is back at zero.
    assign w_load = (r_bit_cnt == 3'd0);

    // State register: reset always restarts the full SYNC sequence.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: leave SYNC on the load of the last COM symbol; ACTIVE is sticky.
    always_comb begin
        w_state_next = r_state;
        if (r_state == S_SYNC && w_load && r_sync_cnt == SYNC_LAST) begin
            w_state_next = S_ACTIVE;
        end
    end

    // Outputs of the FSM: which symbol to load and whether the user is served.
    always_comb begin
        w_ready     = 1'b0;
        w_user_load = 1'b0;
        w_sym       = COM_SYMBOL;
        case (r_state)
            S_SYNC: begin
                w_sym = COM_SYMBOL;
            end
            S_ACTIVE: begin
                w_ready     = reset & w_load;
                w_user_load = valid_in & w_load;
                w_sym       = valid_in ? data_in : IDLE_SYMBOL;
            end
            default: begin
                w_sym = COM_SYMBOL;
            end
        endcase
    end

    // Serializer, bit/sync counters, active flag and user byte counter.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_sync_cnt <= '0;
            r_data_out <= 1'b0;
            r_active   <= 1'b0;
            r_byte_cnt <= '0;
        end else begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_active  <= (w_state_next == S_ACTIVE);
            if (w_load) begin
                // MSB goes out on the load edge itself; the rest follow from the shifter.
                r_shift    <= w_sym;
                r_data_out <= w_sym[7];
                if (r_state == S_SYNC) begin
                    r_sync_cnt <= r_sync_cnt + 1'b1;
                end
            end else begin
                r_shift    <= {r_shift[6:0], 1'b0};
                r_data_out <= r_shift[6];
            end
            if (w_user_load) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
        end
    end

    assign ready         = w_ready;
    assign data_out      = r_data_out;
    assign active        = r_active;
    assign data_byte_cnt = r_byte_cnt;

endmodule

// File: tb/tb_paralelo_serial.sv
// Bench for paralelo_serial: directed scenarios plus random traffic,
// compared every clock against an edge-count based reference model.
module tb_paralelo_serial;

    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] IDLE = 8'h7C;
    localparam int         SYNC = 4;

    logic        clk_32f = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [7:0]  data_in;
    logic        ready, data_out, active;
    logic [15:0] data_byte_cnt;
    logic        ready4, data_out4, active4;
    logic [3:0]  data_byte_cnt4;

    int errors = 0;
    int checks = 0;

    // Reference model state: edges since reset release, current symbol, user loads.
    int         m_n   = 0;
    logic [7:0] m_sym = 8'h00;
    int         m_cnt = 0;
    logic       m_do  = 1'b0;
    logic       m_act = 1'b0;

    always #5 clk_32f = ~clk_32f;

    paralelo_serial #(.CNT_WIDTH(16)) dut (
        .clk_32f(clk_32f), .reset(rst_n), .valid_in(valid_in), .data_in(data_in),
        .ready(ready), .data_out(data_out), .active(active), .data_byte_cnt(data_byte_cnt)
    );

    paralelo_serial #(.CNT_WIDTH(4)) dut4 (
        .clk_32f(clk_32f), .reset(rst_n), .valid_in(valid_in), .data_in(data_in),
        .ready(ready4), .data_out(data_out4), .active(active4), .data_byte_cnt(data_byte_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, check ready, apply the edge to the model, check outputs.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        logic exp_rdy;
        int   pos;
        rst_n    = r;
        valid_in = v;
        data_in  = d;
        #1;
        exp_rdy = r && (m_n % 8 == 0) && (m_n / 8 >= SYNC);
        chk("ready", ready, exp_rdy);
        @(posedge clk_32f);
        if (!r) begin
            m_n = 0; m_cnt = 0; m_do = 1'b0; m_act = 1'b0; m_sym = 8'h00;
        end else begin
            m_n++;
            pos = (m_n - 1) % 8;
            if (pos == 0) begin
                if ((m_n - 1) / 8 < SYNC) m_sym = COM;
                else if (v) begin m_sym = d; m_cnt++; end
                else m_sym = IDLE;
            end
            m_do  = m_sym[7 - pos];
            m_act = (m_n >= 8 * (SYNC - 1) + 1);
        end
        @(negedge clk_32f);
        chk("data_out", data_out, m_do);
        chk("active", active, m_act);
        chk("byte_cnt", data_byte_cnt, m_cnt & 32'hFFFF);
        chk("byte_cnt4", data_byte_cnt4, m_cnt & 32'hF);
        chk("data_out4", data_out4, m_do);
    endtask

    initial begin
        logic [7:0] t3 [3];
        logic [7:0] bits;
        t3[0] = 8'h00; t3[1] = 8'hFF; t3[2] = 8'hBC;
        rst_n = 1'b0; valid_in = 1'b0; data_in = 8'h00;
        @(negedge clk_32f);

        // T1: reset, then COM x4 followed by IDLE
        repeat (3) step(1'b0, 1'b0, 8'h00);
        chk("rst_active", active, 1'b0);
        chk("rst_data_out", data_out, 1'b0);
        chk("rst_cnt", data_byte_cnt, 0);
        for (int i = 1; i <= 32; i++) begin
            step(1'b1, 1'b0, 8'h00);
            bits[7 - ((i - 1) % 8)] = data_out;
            if (i == 8) chk("t1_com0", bits, 8'hBC);
            if (i == 24) chk("t1_pre_active", active, 1'b0);
            if (i == 25) chk("t1_active", active, 1'b1);
            if (i == 32) chk("t1_com3", bits, 8'hBC);
        end

        // T2: A5 at edge 33
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0), (i == 0) ? 8'hA5 : 8'h00);
            bits[7 - i] = data_out;
            if (i == 0) chk("t2_cnt", data_byte_cnt, 1);
        end
        chk("t2_bits", bits, 8'hA5);

        // T4: valid only on non-load edges -> IDLE twice, count unchanged
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i % 8 >= 2 && i % 8 <= 5), 8'(i * 17 + 3));
            bits[7 - (i % 8)] = data_out;
            if (i % 8 == 7) chk("t4_idle", bits, 8'h7C);
        end
        chk("t4_cnt", data_byte_cnt, 1);

        // T3: back-to-back 00, FF, BC
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'b1, t3[i / 8]);
            bits[7 - (i % 8)] = data_out;
            if (i % 8 == 7) chk("t3_byte", bits, t3[i / 8]);
        end
        chk("t3_cnt", data_byte_cnt, 4);

        // T5: reset in the middle of a data byte
        for (int i = 0; i < 4; i++) step(1'b1, (i == 0), 8'h5A);
        step(1'b0, 1'b0, 8'h00);
        chk("t5_data_out", data_out, 1'b0);
        chk("t5_active", active, 1'b0);
        chk("t5_cnt", data_byte_cnt, 0);
        for (int i = 1; i <= 25; i++) begin
            step(1'b1, 1'b1, 8'hFF);
            if (i == 24) chk("t5_pre_active", active, 1'b0);
        end
        chk("t5_active_again", active, 1'b1);
        chk("t5_cnt_sync", data_byte_cnt, 0);
        repeat (7) step(1'b1, 1'b0, 8'h00);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 399) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // T6: 4-bit counter wrap over 17 consecutive loads
        step(1'b0, 1'b0, 8'h00);
        repeat (32) step(1'b1, 1'b0, 8'h00);
        for (int k = 1; k <= 17; k++) begin
            step(1'b1, 1'b1, 8'($urandom));
            if (k == 15) chk("t6_15", data_byte_cnt4, 15);
            if (k == 16) chk("t6_16", data_byte_cnt4, 0);
            if (k == 17) chk("t6_17", data_byte_cnt4, 1);
            repeat (7) step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
        end
        chk("t6_cnt16", data_byte_cnt, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
